vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/ppu_pkg.sv | 19 +
 rtl/vram_wr_fifo.sv | 59 +++++
 rtl/vram_arbiter.sv | 141 ++++++++++++++
 tb/tb_vram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg -- shared definitions for the PPU / VRAM path.
//   vram_state_t  : video timing phase seen by the VRAM arbiter
//   PIX_INVALID   : pix_x/pix_y value outside the active area
//   VBLANK_RUN    : consecutive blank cycles after which blanking is vertical
//   HBLANK_GUARD  : last blank_run value (exclusive) at which HBLANK writes may start
package ppu_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    HBLANK = 2'd1,
    VBLANK = 2'd2
  } vram_state_t;

  localparam logic [11:0] PIX_INVALID   = 12'hFFF;
  localparam logic [10:0] VBLANK_RUN    = 11'd255;
  localparam logic [10:0] HBLANK_GUARD  = 11'd150;
  localparam logic [10:0] BLANK_RUN_MAX = 11'd2047;

endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo -- synchronous first-word-fall-through FIFO for queued CPU writes.
//   vga_clk, rstn  : clock, asynchronous active-low reset (discards contents)
//   push/push_data : write an entry (ignored when full)
//   pop            : consume the head entry (ignored when empty)
//   head           : current head entry, valid whenever empty=0
//   empty, level   : status; level counts entries 0..DEPTH
// DEPTH must be a power of two in 2..16 so the pointers wrap naturally.
module vram_wr_fifo #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned DEPTH = 4
) (
  input  logic             vga_clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [4:0]       level
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [4:0]       count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count < 5'(DEPTH));
  assign do_pop  = pop && (count != 5'd0);

  always_ff @(posedge vga_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge vga_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == 5'd0);
  assign level = count;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter -- shares a single-port VRAM between PPU reads and queued CPU writes.
//   vga_clk, rstn              : pixel clock, asynchronous active-low reset
//   pix_x, pix_y               : active-area coordinates, 12'hFFF when blanking
//   ppu_req/ppu_addr           : PPU read, always wins the RAM in the same cycle
//   ppu_rvalid/ppu_rdata       : read return one cycle after ppu_req
//   cpu_wr_valid/ready/addr/data : CPU write into the write FIFO
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata : single-port RAM, 1-cycle read
//   fifo_level                 : queued CPU writes
//   frame_start                : one-cycle pulse at the first pixel of a frame
// Build option: define VRAM_ARB_HBLANK_WR_EN to also drain the FIFO early in
// horizontal blanking; otherwise writes drain only during vertical blanking.
module vram_arbiter
  import ppu_pkg::*;
#(
  parameter int unsigned AW    = 15,
  parameter int unsigned DEPTH = 4
) (
  input  logic          vga_clk,
  input  logic          rstn,
  input  logic [11:0]   pix_x,
  input  logic [11:0]   pix_y,
  input  logic          ppu_req,
  input  logic [AW-1:0] ppu_addr,
  output logic          ppu_rvalid,
  output logic [11:0]   ppu_rdata,
  input  logic          cpu_wr_valid,
  output logic          cpu_wr_ready,
  input  logic [AW-1:0] cpu_wr_addr,
  input  logic [11:0]   cpu_wr_data,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [11:0]   ram_wdata,
  input  logic [11:0]   ram_rdata,
  output logic [4:0]    fifo_level,
  output logic          frame_start
);

  localparam int unsigned FW = AW + 12;

  vram_state_t   state_q;
  vram_state_t   state_d;
  logic [10:0]   blank_run;
  logic          active;
  logic          wr_window;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic [FW-1:0] fifo_head;
  logic [AW-1:0] head_addr;
  logic [11:0]   head_data;

  assign active = (pix_x != PIX_INVALID);

  // Length of the current blanking stretch; long stretches mean vertical blank.
  always_ff @(posedge vga_clk or negedge rstn) begin
    if (!rstn) begin
      blank_run <= '0;
    end else if (active) begin
      blank_run <= '0;
    end else if (blank_run != BLANK_RUN_MAX) begin
      blank_run <= blank_run + 11'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge rstn) begin
    if (!rstn) state_q <= VBLANK;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (active) begin
      state_d = ACTIVE;
    end else if (blank_run >= VBLANK_RUN) begin
      state_d = VBLANK;
    end else if (state_q != VBLANK) begin
      state_d = HBLANK;
    end
  end

`ifdef VRAM_ARB_HBLANK_WR_EN
  // HBLANK writes stop well before the blank ends so a queued write can never
  // collide with the PPU fetches that precede the next active line.
  assign wr_window = (state_q == VBLANK) ||
                     ((state_q == HBLANK) && (blank_run < HBLANK_GUARD));
`else
  assign wr_window = (state_q == VBLANK);
`endif

  assign cpu_wr_ready = (fifo_level < 5'(DEPTH));
  assign fifo_push    = cpu_wr_valid && cpu_wr_ready;
  // A write blocked by the PPU simply is not popped, so it retries in place.
  assign fifo_pop     = !ppu_req && wr_window && !fifo_empty;

  vram_wr_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_wr_fifo (
    .vga_clk   (vga_clk),
    .rstn      (rstn),
    .push      (fifo_push),
    .push_data ({cpu_wr_addr, cpu_wr_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign {head_addr, head_data} = fifo_head;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (ppu_req) begin
      ram_en   = 1'b1;
      ram_addr = ppu_addr;
    end else if (fifo_pop) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = head_addr;
      ram_wdata = head_data;
    end
  end

  always_ff @(posedge vga_clk or negedge rstn) begin
    if (!rstn) begin
      ppu_rvalid  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      ppu_rvalid  <= ppu_req;
      // Pixel (0,0) after any blanking: only the first pixel of a frame.
      frame_start <= (pix_x == 12'd0) && (pix_y == 12'd0) && (state_q != ACTIVE);
    end
  end

  assign ppu_rdata = ram_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  localparam int unsigned AW    = 15;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LINE  = 24;
  localparam int unsigned HACT  = 16;
  localparam int unsigned LINES = 525;
  localparam int unsigned VACT  = 480;

`ifdef VRAM_ARB_HBLANK_WR_EN
  localparam int unsigned FIRST_WR = 1;
`else
  localparam int unsigned FIRST_WR = 256;
`endif

  logic          vga_clk;
  logic          rstn;
  logic [11:0]   pix_x;
  logic [11:0]   pix_y;
  logic          ppu_req;
  logic [AW-1:0] ppu_addr;
  logic          ppu_rvalid;
  logic [11:0]   ppu_rdata;
  logic          cpu_wr_valid;
  logic          cpu_wr_ready;
  logic [AW-1:0] cpu_wr_addr;
  logic [11:0]   cpu_wr_data;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [11:0]   ram_wdata;
  logic [11:0]   ram_rdata;
  logic [4:0]    fifo_level;
  logic          frame_start;

  vram_arbiter #(.AW(AW), .DEPTH(DEPTH)) dut (
    .vga_clk      (vga_clk),
    .rstn         (rstn),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .ppu_req      (ppu_req),
    .ppu_addr     (ppu_addr),
    .ppu_rvalid   (ppu_rvalid),
    .ppu_rdata    (ppu_rdata),
    .cpu_wr_valid (cpu_wr_valid),
    .cpu_wr_ready (cpu_wr_ready),
    .cpu_wr_addr  (cpu_wr_addr),
    .cpu_wr_data  (cpu_wr_data),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .fifo_level   (fifo_level),
    .frame_start  (frame_start)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int unsigned cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  logic [AW-1:0] log_addr[$];
  logic [11:0]   log_data[$];
  int unsigned   log_cyc[$];
  int unsigned   fs_cyc[$];

  always @(negedge vga_clk) begin
    if (rstn && ram_en && ram_we) begin
      log_addr.push_back(ram_addr);
      log_data.push_back(ram_wdata);
      log_cyc.push_back(cyc);
    end
    if (frame_start) fs_cyc.push_back(cyc);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  int unsigned b0;
  int unsigned f0;

  initial begin
    rstn         = 1'b0;
    pix_x        = 12'd0;
    pix_y        = 12'd0;
    ppu_req      = 1'b1;
    ppu_addr     = AW'(32'h42);
    cpu_wr_valid = 1'b0;
    cpu_wr_addr  = '0;
    cpu_wr_data  = '0;
    ram_rdata    = 12'h5A5;

    // Reset with 3 writes offered and pixel (0,0) present.
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = AW'(32'h10 + i);
      cpu_wr_data  = 12'(32'h900 + i);
      tick();
    end
    cpu_wr_valid = 1'b0;
    check("rst_level",       32'(fifo_level), 0);
    check("rst_rvalid",      32'(ppu_rvalid), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_ppu_addr",    32'(ram_addr), 32'h42);

    ppu_req = 1'b0;
    pix_x   = 12'd5;
    pix_y   = 12'd5;
    #1;
    rstn = 1'b1;
    tick();
    check("rel_level",  32'(fifo_level), 0);
    check("rel_ready",  32'(cpu_wr_ready), 1);
    check("rel_ram_en", 32'(ram_en), 0);

    // Fill the FIFO during active video; nothing may drain.
    repeat (2) tick();
    clear_log();
    for (int i = 0; i < 4; i++) begin
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = AW'(32'h100 + i);
      cpu_wr_data  = 12'(32'hA00 + i);
      #1;
      check($sformatf("fill_ready%0d", i), 32'(cpu_wr_ready), 1);
      tick();
    end
    cpu_wr_addr = AW'(32'h104);
    cpu_wr_data = 12'hA04;
    #1;
    check("full_level", 32'(fifo_level), 4);
    check("full_ready", 32'(cpu_wr_ready), 0);
    tick();
    check("stall_level", 32'(fifo_level), 4);
    cpu_wr_valid = 1'b0;
    check("active_no_we", 32'(log_addr.size()), 0);

    // Long blank: drain in push order at the window opening.
    pix_x = 12'hFFF;
    pix_y = 12'hFFF;
    b0 = cyc;
    repeat (270) tick();
    check("drain_count", 32'(log_addr.size()), 4);
    if (log_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("drain_addr%0d", i), 32'(log_addr[i]), 32'h100 + i);
        check($sformatf("drain_data%0d", i), 32'(log_data[i]), 32'hA00 + i);
        check($sformatf("drain_cyc%0d", i), log_cyc[i], b0 + FIRST_WR + i);
      end
    end
    check("drain_level", 32'(fifo_level), 0);

    // PPU preempts a VBLANK drain; the blocked entry retries.
    ppu_req  = 1'b1;
    ppu_addr = AW'(32'h123);
    for (int i = 0; i < 3; i++) begin
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = AW'(32'h200 + i);
      cpu_wr_data  = 12'(32'hB00 + i);
      #1;
      check($sformatf("ppu_hold_we%0d", i), 32'(ram_we), 0);
      check($sformatf("ppu_hold_addr%0d", i), 32'(ram_addr), 32'h123);
      tick();
    end
    cpu_wr_valid = 1'b0;
    check("ppu_rvalid_hi", 32'(ppu_rvalid), 1);
    check("preempt_level", 32'(fifo_level), 3);
    ppu_req = 1'b0;
    #1;
    check("drain0_we",    32'(ram_we), 1);
    check("drain0_addr",  32'(ram_addr), 32'h200);
    check("drain0_wdata", 32'(ram_wdata), 32'hB00);
    tick();
    check("rvalid_lo", 32'(ppu_rvalid), 0);
    ppu_req = 1'b1;
    #1;
    check("preempt_en",   32'(ram_en), 1);
    check("preempt_we",   32'(ram_we), 0);
    check("preempt_addr", 32'(ram_addr), 32'h123);
    tick();
    check("preempt_rvalid", 32'(ppu_rvalid), 1);
    check("preempt_rdata",  32'(ppu_rdata), 32'h5A5);
    ram_rdata = 12'h3C3;
    #1;
    check("rdata_pass", 32'(ppu_rdata), 32'h3C3);
    ppu_req = 1'b0;
    #1;
    check("resume_we",    32'(ram_we), 1);
    check("resume_addr",  32'(ram_addr), 32'h201);
    check("resume_wdata", 32'(ram_wdata), 32'hB01);
    tick();
    check("resume2_addr", 32'(ram_addr), 32'h202);
    tick();
    check("resume_level", 32'(fifo_level), 0);
    check("idle_en",      32'(ram_en), 0);

    // Push into an empty FIFO is not popped in the same cycle.
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = AW'(32'h250);
    cpu_wr_data  = 12'hC50;
    #1;
    check("empty_push_no_we", 32'(ram_we), 0);
    tick();
    cpu_wr_valid = 1'b0;
    #1;
    check("empty_push_we",   32'(ram_we), 1);
    check("empty_push_addr", 32'(ram_addr), 32'h250);
    tick();
    check("empty_push_level", 32'(fifo_level), 0);

    // Simultaneous push and pop at level 2.
    ppu_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = AW'(32'h260 + i);
      cpu_wr_data  = 12'(32'hC60 + i);
      tick();
    end
    ppu_req     = 1'b0;
    cpu_wr_addr = AW'(32'h262);
    cpu_wr_data = 12'hC62;
    #1;
    check("pp_we",   32'(ram_we), 1);
    check("pp_addr", 32'(ram_addr), 32'h260);
    tick();
    cpu_wr_valid = 1'b0;
    check("pp_level", 32'(fifo_level), 2);
    repeat (2) tick();
    check("pp_drained", 32'(fifo_level), 0);

    // One entry queued across an HBLANK.
    pix_x = 12'd3;
    pix_y = 12'd3;
    repeat (3) tick();
    clear_log();
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = AW'(32'h300);
    cpu_wr_data  = 12'hD00;
    tick();
    cpu_wr_valid = 1'b0;
    tick();
    check("hb_active_no_we", 32'(log_addr.size()), 0);
    pix_x = 12'hFFF;
    pix_y = 12'hFFF;
    b0 = cyc;
    repeat (270) tick();
    check("hb_count", 32'(log_addr.size()), 1);
    if (log_addr.size() == 1) begin
      check("hb_addr", 32'(log_addr[0]), 32'h300);
      check("hb_cyc",  log_cyc[0], b0 + FIRST_WR);
    end

    // Two compressed 525-line frames.
    fs_cyc.delete();
    f0 = 0;
    for (int f = 0; f < 2; f++) begin
      for (int y = 0; y < int'(LINES); y++) begin
        for (int x = 0; x < int'(LINE); x++) begin
          if (y < int'(VACT) && x < int'(HACT)) begin
            pix_x = 12'(x);
            pix_y = 12'(y);
          end else begin
            pix_x = 12'hFFF;
            pix_y = 12'hFFF;
          end
          if (f == 0 && y == 0 && x == 0) f0 = cyc;
          tick();
        end
      end
    end
    repeat (2) tick();
    check("fs_count", 32'(fs_cyc.size()), 2);
    if (fs_cyc.size() == 2) begin
      check("fs_first",   fs_cyc[0], f0 + 1);
      check("fs_spacing", fs_cyc[1] - fs_cyc[0], LINE * LINES);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
